// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte-wide UART transmitter between N_REQ
// byte-stream requesters, one whole frame at a time, with an optional ID header.
module uart_tx_arbiter #(
    parameter int         N_REQ     = 4,
    parameter int         ID_PREFIX = 1,
    parameter logic [7:0] ID_BASE   = 8'hA0,
    parameter int         TIMEOUT   = 1023,
    localparam int        GW        = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic [GW-1:0]      grant_id,
    output logic               active,
    output logic               err_timeout,
    output logic [2:0]         dbg_state_o
);

    // Handshake: requester i hands over a byte in any cycle where req_valid[i]
    // and req_ready[i] are both high; req_data/req_last are only looked at then.

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [GW:0]    N_REQ_W  = (GW + 1)'(N_REQ);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        DATA    = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [GW-1:0]  last_grant_q, last_grant_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_start_q, tx_start_d;
    logic           err_q, err_d;
    logic           hdr_flag_q, hdr_flag_d;
    logic           last_flag_q, last_flag_d;

    logic           rr_found;
    logic [GW-1:0]  rr_pick;
    logic [GW:0]    rr_idx;
    logic           xfer;

    // Scan requesters starting just after the previous winner, wrapping around.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            rr_idx = {1'b0, last_grant_q} + (GW + 1)'(k);
            if (rr_idx >= N_REQ_W) begin
                rr_idx = rr_idx - N_REQ_W;
            end
            if (!rr_found && req_valid[rr_idx[GW-1:0]]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx[GW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = (state_q == DATA) && (grant_q == GW'(i)) && !tx_busy;
        end
    end

    assign xfer = req_valid[grant_q] && req_ready[grant_q];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        err_d        = 1'b0;
        hdr_flag_d   = hdr_flag_q;
        last_flag_d  = last_flag_q;

        case (state_q)
            IDLE: begin
                hdr_flag_d = 1'b0;
                if (rr_found) begin
                    grant_d = rr_pick;
                    cnt_d   = '0;
                    state_d = (ID_PREFIX != 0) ? HDR : DATA;
                end
            end

            HDR: begin
                if (!tx_busy) begin
                    tx_data_d  = ID_BASE + 8'(grant_q);
                    tx_start_d = 1'b1;
                    hdr_flag_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = WAIT_HI;
                end
            end

            DATA: begin
                if (xfer) begin
                    tx_data_d   = req_data[{grant_q, 3'b000} +: 8];
                    last_flag_d = req_last[grant_q];
                    hdr_flag_d  = 1'b0;
                    tx_start_d  = 1'b1;
                    cnt_d       = '0;
                    state_d     = WAIT_HI;
                end else if (cnt_q == TMO_LAST) begin
                    err_d        = 1'b1;
                    last_grant_d = grant_q;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            WAIT_HI: begin
                if (tx_busy) begin
                    cnt_d   = '0;
                    state_d = WAIT_LO;
                end else if (cnt_q == TMO_LAST) begin
                    err_d        = 1'b1;
                    last_grant_d = grant_q;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            WAIT_LO: begin
                // The header byte is never the end of a frame, so it always continues to DATA.
                if (!tx_busy) begin
                    cnt_d = '0;
                    if (hdr_flag_q) begin
                        hdr_flag_d = 1'b0;
                        state_d    = DATA;
                    end else if (last_flag_q) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_REQ - 1);
            cnt_q        <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            err_q        <= 1'b0;
            hdr_flag_q   <= 1'b0;
            last_flag_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            err_q        <= err_d;
            hdr_flag_q   <= hdr_flag_d;
            last_flag_q  <= last_flag_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign grant_id    = grant_q;
    assign active      = (state_q != IDLE);
    assign err_timeout = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: randomized requester traffic and a busy-line model,
// with a frame-level arbitration model feeding a scoreboard of expected TX bytes.
module tb_uart_tx_arbiter;

    localparam int         N    = 4;
    localparam int         T    = 100;
    localparam logic [7:0] BASE = 8'hA0;
    localparam int         LIM  = 20000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           active;
    logic           err_timeout;
    logic [2:0]     dbg_state;

    uart_tx_arbiter #(
        .N_REQ(N), .ID_PREFIX(1), .ID_BASE(BASE), .TIMEOUT(T)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .grant_id(grant_id), .active(active), .err_timeout(err_timeout),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0;
    int err_cnt = 0;
    int last_start_cyc = 0;
    int last_err_cyc = 0;
    int hs_cnt [N];
    int gap [N];
    int gap_max = 0;
    int busy_min = 1;
    int busy_max = 8;
    bit tx_en = 1'b1;
    int busy_cnt = 0;
    logic prev_start = 1'b0;
    logic [N-1:0] drv_hs;

    logic [15:0] exp_q[$];
    logic [8:0]  src_q [N][$];
    logic [8:0]  m_src [N][$];
    int          m_last = N - 1;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter stand-in: busy rises the cycle after tx_start for a random length.
    always @(posedge clk) begin
        if (!tx_en) busy_cnt <= 0;
        else if (tx_start) busy_cnt <= $urandom_range(busy_max, busy_min);
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int rr_next(input int last, input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic exp_push(input int g, input logic [7:0] b);
        exp_q.push_back({8'(g), b});
    endtask

    task automatic push_byte(input int i, input logic [7:0] b, input bit last, input bit to_model);
        src_q[i].push_back({last, b});
        if (to_model) m_src[i].push_back({last, b});
    endtask

    task automatic load_frame(input int i, input int len);
        for (int j = 0; j < len; j++) begin
            push_byte(i, 8'($urandom_range(255, 0)), (j == len - 1), 1'b1);
        end
    endtask

    // Frame-level reference: each pending frame becomes header + its bytes, in RR order.
    task automatic model_run();
        logic [N-1:0] mask;
        logic [8:0]   e;
        int           g;
        forever begin
            for (int i = 0; i < N; i++) mask[i] = (m_src[i].size() != 0);
            if (mask == '0) break;
            g = rr_next(m_last, mask);
            exp_push(g, BASE + 8'(g));
            do begin
                e = m_src[g].pop_front();
                exp_push(g, e[7:0]);
            end while (!e[8]);
            m_last = g;
        end
    endtask

    task automatic monitor_loop();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_start = 1'b0;
            end else begin
                if (tx_start) begin
                    start_cnt++;
                    last_start_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got grant %0d byte %0h, expected no tx_start (cycle %0d)",
                                 grant_id, tx_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_grant_byte", 32'({8'(grant_id), tx_data}), 32'(e));
                    end
                    chk("tx_start_while_busy", 32'(tx_busy), 32'(0));
                    chk("tx_start_back_to_back", 32'(prev_start), 32'(0));
                end
                prev_start = tx_start;
                if (err_timeout) begin
                    err_cnt++;
                    last_err_cyc = cyc;
                end
                if (req_ready != '0) begin
                    chk("ready_only_grant", 32'(req_ready), 32'(4'b0001 << grant_id));
                    chk("ready_while_busy", 32'(tx_busy), 32'(0));
                    chk("ready_while_idle", 32'(active), 32'(1));
                end
            end
        end
    endtask

    task automatic driver_loop();
        logic [8:0] head;
        forever begin
            @(negedge clk);
            drv_hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (drv_hs[i] && src_q[i].size() != 0) begin
                    head = src_q[i].pop_front();
                    hs_cnt[i]++;
                    if (!head[8]) gap[i] = $urandom_range(gap_max, 0);
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end
                if (src_q[i].size() != 0 && gap[i] == 0) begin
                    head = src_q[i][0];
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = head[7:0];
                    req_last[i] = head[8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic do_reset(input bit check_vals);
        tick();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            m_src[i].delete();
            gap[i] = 0;
        end
        chk("exp_empty_before_reset", 32'(exp_q.size()), 32'(0));
        exp_q.delete();
        m_last = N - 1;
        @(posedge clk);
        tick();
        if (check_vals) begin
            chk("rst_tx_data", 32'(tx_data), 32'(0));
            chk("rst_tx_start", 32'(tx_start), 32'(0));
            chk("rst_req_ready", 32'(req_ready), 32'(0));
            chk("rst_grant_id", 32'(grant_id), 32'(0));
            chk("rst_active", 32'(active), 32'(0));
            chk("rst_err_timeout", 32'(err_timeout), 32'(0));
            chk("rst_state", 32'(dbg_state), 32'(0));
        end
        rst = 1'b0;
    endtask

    task automatic wait_starts(input int target, input string nm);
        for (int n = 0; n < LIM && start_cnt < target; n++) tick();
        chk(nm, 32'(start_cnt), 32'(target));
    endtask

    task automatic wait_busy(input logic level);
        int n;
        for (n = 0; n < LIM && tx_busy !== level; n++) tick();
        chk("wait_tx_busy", 32'(tx_busy), 32'(level));
    endtask

    task automatic wait_err(input int target);
        for (int n = 0; n < LIM && err_cnt < target; n++) tick();
        chk("wait_err_timeout", 32'(err_cnt), 32'(target));
    endtask

    task automatic wait_drained();
        for (int n = 0; n < LIM && (exp_q.size() != 0 || active); n++) tick();
        chk("drain_exp_q", 32'(exp_q.size()), 32'(0));
        chk("drain_idle", 32'(active), 32'(0));
    endtask

    initial begin
        int base, h0, e0, fall;
        logic [7:0] b;
        for (int i = 0; i < N; i++) begin
            hs_cnt[i] = 0;
            gap[i] = 0;
        end
        fork
            monitor_loop();
            driver_loop();
        join_none

        do_reset(1'b1);

        // All four requesters valid with single-byte frames: strict rotation.
        busy_min = 1; busy_max = 8;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < N; i++) load_frame(i, 1);
        model_run();
        wait_drained();

        // Single 3-byte frame from requester 0 with a 10-cycle busy line.
        busy_min = 10; busy_max = 10;
        base = start_cnt;
        h0 = hs_cnt[0];
        push_byte(0, 8'h11, 1'b0, 1'b1);
        push_byte(0, 8'h22, 1'b0, 1'b1);
        push_byte(0, 8'h33, 1'b1, 1'b1);
        model_run();
        wait_starts(base + 4, "frame0_starts");
        wait_busy(1'b1);
        wait_busy(1'b0);
        chk("frame0_active_at_busy_fall", 32'(active), 32'(1));
        tick();
        chk("frame0_active_after", 32'(active), 32'(0));
        chk("frame0_handshakes", 32'(hs_cnt[0] - h0), 32'(3));
        for (int n = 0; n < 20; n++) tick();
        chk("frame0_start_total", 32'(start_cnt), 32'(base + 4));

        // Requester 2 shows up mid-frame of requester 0 and must wait its turn.
        busy_min = 2; busy_max = 6;
        h0 = hs_cnt[0];
        load_frame(0, 3);
        model_run();
        for (int n = 0; n < LIM && hs_cnt[0] == h0; n++) tick();
        chk("lock_first_byte_taken", 32'(hs_cnt[0] - h0), 32'(1));
        load_frame(2, 1);
        model_run();
        wait_drained();

        // Randomized traffic with mid-frame valid gaps.
        gap_max = 3; busy_min = 1; busy_max = 8;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                int nf;
                nf = $urandom_range(3, 0);
                for (int f = 0; f < nf; f++) load_frame(i, $urandom_range(5, 1));
            end
            model_run();
            wait_drained();
        end
        gap_max = 0;

        // Busy line never rises: header aborts after T cycles, grant rotates to 1.
        do_reset(1'b0);
        tx_en = 1'b0;
        e0 = err_cnt;
        base = start_cnt;
        push_byte(0, 8'h5A, 1'b1, 1'b0);
        push_byte(1, 8'h6B, 1'b1, 1'b0);
        exp_push(rr_next(N - 1, 4'b0011), BASE + 8'(rr_next(N - 1, 4'b0011)));
        exp_push(rr_next(0, 4'b0011), BASE + 8'(rr_next(0, 4'b0011)));
        wait_starts(base + 1, "tmo_hdr0_start");
        wait_err(e0 + 1);
        chk("tmo_hi_latency0", 32'(last_err_cyc - last_start_cyc), 32'(T));
        wait_starts(base + 2, "tmo_hdr1_start");
        for (int i = 0; i < N; i++) src_q[i].delete();
        wait_err(e0 + 2);
        chk("tmo_hi_latency1", 32'(last_err_cyc - last_start_cyc), 32'(T));
        for (int n = 0; n < 10; n++) tick();
        chk("tmo_idle_after", 32'(active), 32'(0));
        chk("tmo_no_extra_start", 32'(start_cnt), 32'(base + 2));
        m_last = 1;

        // Requester 1 sends one non-last byte then goes silent: stall timeout in DATA.
        tx_en = 1'b1;
        busy_min = 10; busy_max = 10;
        e0 = err_cnt;
        base = start_cnt;
        b = 8'($urandom_range(255, 0));
        push_byte(1, b, 1'b0, 1'b0);
        exp_push(rr_next(m_last, 4'b0010), BASE + 8'(rr_next(m_last, 4'b0010)));
        exp_push(rr_next(m_last, 4'b0010), b);
        wait_starts(base + 2, "stall_starts");
        wait_busy(1'b1);
        wait_busy(1'b0);
        fall = cyc;
        wait_err(e0 + 1);
        chk("stall_latency", 32'(last_err_cyc - fall), 32'(T + 1));
        for (int n = 0; n < 20; n++) tick();
        chk("stall_no_extra_start", 32'(start_cnt), 32'(base + 2));
        chk("stall_idle_after", 32'(active), 32'(0));
        m_last = 1;

        // Reset while the second data byte is on the line.
        base = start_cnt;
        push_byte(0, 8'hC1, 1'b0, 1'b0);
        push_byte(0, 8'hC2, 1'b0, 1'b0);
        push_byte(0, 8'hC3, 1'b1, 1'b0);
        exp_push(rr_next(m_last, 4'b0001), BASE + 8'(rr_next(m_last, 4'b0001)));
        exp_push(rr_next(m_last, 4'b0001), 8'hC1);
        exp_push(rr_next(m_last, 4'b0001), 8'hC2);
        wait_starts(base + 3, "rstmid_starts");
        wait_busy(1'b1);
        tick();
        chk("rstmid_in_wait_lo", 32'(dbg_state), 32'(4));
        do_reset(1'b1);
        load_frame(3, 2);
        load_frame(0, 2);
        model_run();
        wait_drained();

        chk("err_pulse_total", 32'(err_cnt), 32'(3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
